// File: rtl/hash_table_pkg.sv
// Shared hash-table types: command payload, opcodes and the source tag used
// for routing results back to the issuing source.
package hash_table;

    localparam int unsigned KEY_WIDTH   = 32;
    localparam int unsigned VALUE_WIDTH = 16;
    localparam int unsigned OP_WIDTH    = 3;

    // Opcodes are a plain vector so illegal encodings can travel untouched.
    typedef logic [OP_WIDTH-1:0] ht_opcode_t;

    localparam ht_opcode_t OP_NOP    = 3'd0;
    localparam ht_opcode_t OP_INSERT = 3'd1;
    localparam ht_opcode_t OP_DELETE = 3'd2;
    localparam ht_opcode_t OP_SEARCH = 3'd3;

    // Source tag sized for the largest supported arbiter (8 sources).
    localparam int unsigned SRC_MAX = 8;
    typedef logic [$clog2(SRC_MAX)-1:0] ht_src_t;

    typedef struct packed {
        ht_opcode_t             op;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } ht_command_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans requests starting just after the last winner.
// The pointer only moves when the consumer strobes advance_i.
module rr_arbiter #(
    parameter int unsigned  N     = 2,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] ptr_q;

    // Pointer starts at the last source so source 0 wins first after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= IDX_W'(N - 1);
        end else if (advance_i) begin
            ptr_q <= idx_o;
        end
    end

    // First requester from ptr_q+1 upward, wrapping modulo N.
    always_comb begin
        int               pos;
        logic             found;
        logic [IDX_W-1:0] pos_idx;
        gnt_o   = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int off = 1; off <= int'(N); off++) begin
            pos = int'(ptr_q) + off;
            if (pos >= int'(N)) begin
                pos = pos - int'(N);
            end
            pos_idx = IDX_W'(pos);
            if (!found && req_i[pos_idx]) begin
                found          = 1'b1;
                gnt_o[pos_idx] = 1'b1;
                idx_o          = pos_idx;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/ht_cmd_arb.sv
// Round-robin merge of SRC_CNT command sources into the hash table command
// stream, with one registered output stage tagged by source index.
// Optional per-source grant / stall statistics: define HT_CMD_ARB_STATS_EN.
module ht_cmd_arb
    import hash_table::*;
#(
    parameter int unsigned  SRC_CNT = 2,
    parameter int unsigned  CNT_W   = 32,
    localparam int unsigned SRC_W   = $clog2(SRC_CNT)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  ht_command_t         cmd_i [SRC_CNT],
    input  logic [SRC_CNT-1:0]  cmd_valid_i,
    output logic [SRC_CNT-1:0]  cmd_ready_o,
    output ht_command_t         cmd_o,
    output logic [SRC_W-1:0]    cmd_src_o,
    output logic                cmd_valid_o,
    input  logic                cmd_ready_i,
    input  logic                stats_clr_i,
    output logic [CNT_W-1:0]    stats_grant_cnt_o [SRC_CNT],
    output logic [CNT_W-1:0]    stats_stall_cnt_o
);

    logic               out_valid_q;
    ht_command_t        cmd_q;
    logic [SRC_W-1:0]   src_q;

    logic [SRC_CNT-1:0] arb_gnt;
    logic [SRC_W-1:0]   arb_idx;
    logic               arb_any;
    logic               load;
    logic               grant;

    rr_arbiter #(
        .N (SRC_CNT)
    ) u_rr_arbiter (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (cmd_valid_i),
        .advance_i (grant),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .any_o     (arb_any)
    );

    // Output stage can take a new command when empty or draining this cycle.
    always_comb begin
        load        = !out_valid_q || cmd_ready_i;
        grant       = load && arb_any;
        cmd_ready_o = grant ? arb_gnt : '0;
    end

    // Output register; payload holds when the stage empties without a grant.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            cmd_q       <= '0;
            src_q       <= '0;
        end else if (load) begin
            out_valid_q <= grant;
            if (grant) begin
                cmd_q <= cmd_i[arb_idx];
                src_q <= arb_idx;
            end
        end
    end

    assign cmd_o       = cmd_q;
    assign cmd_src_o   = src_q;
    assign cmd_valid_o = out_valid_q;

`ifdef HT_CMD_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt_q [SRC_CNT];
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < int'(SRC_CNT); k++) begin
                grant_cnt_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else if (stats_clr_i) begin
            for (int k = 0; k < int'(SRC_CNT); k++) begin
                grant_cnt_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < int'(SRC_CNT); k++) begin
                if (grant && arb_idx == SRC_W'(k) && grant_cnt_q[k] != '1) begin
                    grant_cnt_q[k] <= grant_cnt_q[k] + CNT_W'(1);
                end
            end
            if (out_valid_q && !cmd_ready_i && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stats_grant_cnt_o = grant_cnt_q;
    assign stats_stall_cnt_o = stall_cnt_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr_i;

    // Statistics disabled: outputs tied off, no counter state.
    always_comb begin
        for (int k = 0; k < int'(SRC_CNT); k++) begin
            stats_grant_cnt_o[k] = '0;
        end
    end

    assign stats_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ht_cmd_arb.sv
// Randomized and directed bench for ht_cmd_arb against a queue-free cycle
// model: winner = valid source at smallest forward distance from last winner.
module tb_ht_cmd_arb;
    import hash_table::*;

    localparam int unsigned N     = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SRC_W = $clog2(N);
    localparam int          SAT   = (1 << CNT_W) - 1;
`ifdef HT_CMD_ARB_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    ht_command_t      cmd [N];
    logic [N-1:0]     cmd_valid;
    logic [N-1:0]     cmd_ready_o;
    ht_command_t      cmd_o;
    logic [SRC_W-1:0] cmd_src_o;
    logic             cmd_valid_o;
    logic             cmd_ready;
    logic             stats_clr;
    logic [CNT_W-1:0] grant_cnt [N];
    logic [CNT_W-1:0] stall_cnt;

    ht_cmd_arb #(
        .SRC_CNT (N),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .cmd_i             (cmd),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_o             (cmd_o),
        .cmd_src_o         (cmd_src_o),
        .cmd_valid_o       (cmd_valid_o),
        .cmd_ready_i       (cmd_ready),
        .stats_clr_i       (stats_clr),
        .stats_grant_cnt_o (grant_cnt),
        .stats_stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit          m_valid;
    ht_command_t m_cmd;
    int          m_src;
    int          m_last;
    int          m_gcnt [N];
    int          m_scnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int d = 1; d <= int'(N); d++) begin
            int k;
            k = (last + d) % int'(N);
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic int sat(input int x);
        return (x > SAT) ? SAT : x;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_cmd   = '0;
        m_src   = 0;
        m_last  = int'(N) - 1;
        m_scnt  = 0;
        for (int k = 0; k < int'(N); k++) m_gcnt[k] = 0;
    endtask

    task automatic check_outputs();
        chk_eq("cmd_valid_o", 64'(cmd_valid_o), 64'(m_valid));
        chk_eq("cmd_o", 64'(cmd_o), 64'(m_cmd));
        chk_eq("cmd_src_o", 64'(cmd_src_o), 64'(m_src));
        for (int k = 0; k < int'(N); k++) begin
            chk_eq($sformatf("grant_cnt[%0d]", k), 64'(grant_cnt[k]),
                   STATS_EN ? 64'(m_gcnt[k]) : 64'(0));
        end
        chk_eq("stall_cnt", 64'(stall_cnt), STATS_EN ? 64'(m_scnt) : 64'(0));
    endtask

    // One clock: drive at negedge, check handshake, advance model, check outputs.
    task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic clr,
                         input bit keep_cmds);
        logic         load;
        int           cand;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        if (!keep_cmds) begin
            for (int k = 0; k < int'(N); k++) begin
                cmd[k].op    = 3'($urandom);
                cmd[k].key   = $urandom;
                cmd[k].value = 16'($urandom);
            end
        end
        cmd_valid = v;
        cmd_ready = rdy;
        stats_clr = clr;
        #1;
        load    = !m_valid || rdy;
        cand    = pick(v, m_last);
        exp_rdy = '0;
        if (load && cand >= 0) exp_rdy[cand] = 1'b1;
        chk_eq("cmd_ready_o", 64'(cmd_ready_o), 64'(exp_rdy));
        if (clr) begin
            for (int k = 0; k < int'(N); k++) m_gcnt[k] = 0;
            m_scnt = 0;
        end else begin
            if (load && cand >= 0) m_gcnt[cand] = sat(m_gcnt[cand] + 1);
            if (m_valid && !rdy) m_scnt = sat(m_scnt + 1);
        end
        if (load) begin
            if (cand >= 0) begin
                m_cmd   = cmd[cand];
                m_src   = cand;
                m_valid = 1'b1;
                m_last  = cand;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = '0;
        cmd_ready = 1'b0;
        stats_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_eq("rst_ready_o", 64'(cmd_ready_o), 64'(0));
        check_outputs();
        rst_n = 1'b1;
    endtask

    ht_command_t  ins_cmd;
    ht_command_t  held;
    int           budget;

    initial begin
        for (int k = 0; k < int'(N); k++) cmd[k] = '0;
        do_reset();

        // Single source INSERT from source 1
        ins_cmd.op    = OP_INSERT;
        ins_cmd.key   = 32'h01_00_00_00;
        ins_cmd.value = 16'h1234;
        cmd[1] = ins_cmd;
        cycle(3'b010, 1'b1, 1'b0, 1'b1);
        chk_eq("single_cmd", 64'(cmd_o), 64'(ins_cmd));
        chk_eq("single_src", 64'(cmd_src_o), 64'(1));
        cycle(3'b000, 1'b1, 1'b0, 1'b0);

        // Fairness: sources 0 and 1 both valid, strictly alternating
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(3'b011, 1'b1, 1'b0, 1'b0);
            chk_eq("fair_src", 64'(cmd_src_o), 64'(i % 2));
        end
        chk_eq("fair_cnt0", 64'(grant_cnt[0]), STATS_EN ? 64'(5) : 64'(0));
        chk_eq("fair_cnt1", 64'(grant_cnt[1]), STATS_EN ? 64'(5) : 64'(0));

        // Backpressure: output held, no source accepted, four stall cycles
        held = cmd_o;
        for (int i = 0; i < 4; i++) begin
            cycle(3'b011, 1'b0, 1'b0, 1'b0);
            chk_eq("bp_stable", 64'(cmd_o), 64'(held));
        end
        chk_eq("bp_stall", 64'(stall_cnt), STATS_EN ? 64'(4) : 64'(0));
        cycle(3'b011, 1'b1, 1'b0, 1'b0);
        chk_eq("bp_reload_valid", 64'(cmd_valid_o), 64'(1));

        // Wrap-around: after source 2 wins, scan restarts at 0
        do_reset();
        cycle(3'b100, 1'b1, 1'b0, 1'b0);
        cycle(3'b101, 1'b1, 1'b0, 1'b0);
        chk_eq("wrap_first", 64'(cmd_src_o), 64'(0));
        cycle(3'b101, 1'b1, 1'b0, 1'b0);
        chk_eq("wrap_second", 64'(cmd_src_o), 64'(2));

        // Saturation and clear priority
        do_reset();
        for (int i = 0; i < 20; i++) cycle(3'b001, 1'b1, 1'b0, 1'b0);
        chk_eq("sat_cnt0", 64'(grant_cnt[0]), STATS_EN ? 64'(SAT) : 64'(0));
        cycle(3'b001, 1'b1, 1'b1, 1'b0);
        chk_eq("clr_cnt0", 64'(grant_cnt[0]), 64'(0));

        // Random traffic
        budget = 500;
        for (int i = 0; i < budget; i++) begin
            cycle(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
                  1'b0);
        end

        // Asynchronous reset while output is valid
        cycle(3'b111, 1'b1, 1'b0, 1'b0);
        chk_eq("pre_rst_valid", 64'(cmd_valid_o), 64'(1));
        #2;
        rst_n     = 1'b0;
        cmd_valid = '0;
        #1;
        chk_eq("async_rst_valid", 64'(cmd_valid_o), 64'(0));
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(N'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ht_cmd_arb.md
# ht_cmd_arb

Round-robin command arbiter that merges `SRC_CNT` independent command sources into the single command stream of `hash_table_top`. Sits directly upstream of the hash table, so its output drives `ht_cmd_in`. Each forwarded command is tagged with its source index, which lets downstream logic route results back. Provides one registered output stage and optional per-source grant statistics.

## Interface
- `SRC_CNT`, 2: number of command sources; legal range is 2..8.
- `SRC_W`, `$clog2(SRC_CNT)`: width of the source index (localparam).
- `CNT_W`, 32: width of the statistics counters.

- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `cmd_i[SRC_CNT]`  in  `ht_command_t`  per-source command (opcode, key, value).
- `cmd_valid_i[SRC_CNT]`  in  1  per-source command valid.
- `cmd_ready_o[SRC_CNT]`  out  1  per-source accept.
- `cmd_o`  out  `ht_command_t`  forwarded command; connects to `ht_cmd_in`.
- `cmd_src_o`  out  `SRC_W`  index of the source that issued `cmd_o`.
- `cmd_valid_o`  out  1  output valid.
- `cmd_ready_i`  in  1  hash table ready.
- `stats_clr_i`  in  1  synchronous clear of all counters.
- `stats_grant_cnt_o[SRC_CNT]`  out  `CNT_W`  grants per source.
- `stats_stall_cnt_o`  out  `CNT_W`  cycles where `cmd_valid_o` is high and `cmd_ready_i` is low.

## Operation
- **Output register:** holds `out_valid`, `cmd_o` and `cmd_src_o`.
  - `load = !out_valid || cmd_ready_i`.
- **Arbitration:** runs every cycle.
  - The candidate is the first source with valid high, scanning from `rr_ptr+1` upward and wrapping modulo `SRC_CNT`.
  - `grant = load && any cmd_valid_i`.
- **Source handshake:**
  - `cmd_ready_o[k]` is high only when `grant` is set and `k` is the candidate.
  - At most one `cmd_ready_o` bit is high per cycle.
  - `cmd_ready_o` may combinationally depend on `cmd_valid_i` and `cmd_ready_i`.
  - Sources must not make valid depend on ready.
- **On grant:**
  - `cmd_o <= cmd_i[cand]`, `cmd_src_o <= cand`, `out_valid <= 1`.
  - `rr_ptr <= cand`.
- **On load without grant:** `out_valid <= 0`. `cmd_o` and `cmd_src_o` hold their values (don't-care).
- **Without load:** everything holds. `cmd_o` is stable while `cmd_valid_o && !cmd_ready_i`.
- **Source behaviour:** a source that keeps valid high is served at least once every `SRC_CNT` grants. Commands from one source leave in their arrival order.
- **Payload:** the arbiter does no opcode checking. Opcodes are passed through unmodified, including any illegal encoding.

## Timing
- **Latency:** 1 cycle from the source handshake to `cmd_valid_o`.
- **Throughput:** one command per cycle when `cmd_ready_i` is held high (back-to-back through `load`).
- **Reset values:**
  - `cmd_valid_o = 0`, `cmd_o = '0`, `cmd_src_o = 0`, `cmd_ready_o = 0`.
  - `rr_ptr = SRC_CNT-1`, so source 0 wins first.
  - All counters are 0.
- **Reset mid-operation:** an in-flight `cmd_o` is dropped and not replayed. Sources must re-present their commands.
- **Wrap-around:** when `rr_ptr = SRC_CNT-1`, the scan starts at 0.
- **Simultaneous output and grant:** when `cmd_valid_o && cmd_ready_i` and a new grant occur in the same cycle, the register is replaced with no bubble.
- **Counters:**
  - Counters saturate at `2**CNT_W-1`.
  - `stats_clr_i` clears all counters and has priority over an increment in the same cycle.
  - Counter outputs are registered, with 1-cycle lag after the event.

## Configuration
- Macro: `HT_CMD_ARB_STATS_EN`.
- **Defined:** the counters are implemented as described above.
- **Undefined:**
  - No counter flops are built.
  - `stats_grant_cnt_o` and `stats_stall_cnt_o` are tied to 0.
  - `stats_clr_i` is ignored.
  - Arbitration behaviour is identical in both builds.

## Structure
- `ht_command_t`, `KEY_WIDTH`, `VALUE_WIDTH` and the `OP_*` opcodes come from package `hash_table`.
- A new `ht_src_t` typedef (logic of `SRC_W` bits, sized for the 8-source maximum) is added to `hash_table` so that result-routing logic can share it.
- One sub-module, `rr_arbiter`: `SRC_CNT`-wide request vector in, one-hot grant and encoded index out, with its pointer advanced by an external `advance` strobe.
- Statistics are kept in the top module under `ifdef`.

## Test plan
- **Reset:** assert `rst_n_i` low mid-stream with `cmd_valid_o = 1` -> `cmd_valid_o` drops asynchronously. After release, `cmd_valid_o = 0` and all counters read 0.
- **Single source:** `SRC_CNT=2`, source 1 sends INSERT key `32'h01_00_00_00` value `16'h1234` with `cmd_ready_i = 1` -> next cycle `cmd_o` matches the command, `cmd_src_o = 1`, `cmd_valid_o = 1`.
- **Fairness:** both sources valid continuously for 10 cycles, `cmd_ready_i = 1` -> grants alternate 0,1,0,1,… and with stats enabled each grant counter reads 5.
- **Backpressure:** `cmd_ready_i = 0` for 4 cycles with both sources valid -> `cmd_o` is stable, both `cmd_ready_o` are 0, and the stall counter reads 4. On release, the held command is accepted and the next grant loads in the same cycle.
- **Wrap-around:** `SRC_CNT=3`, sources 0 and 2 valid, last grant was source 2 -> next grant is source 0, then source 2.
- **Build without macro:** same traffic as the fairness scenario -> identical `cmd_o` sequence, and all statistics outputs stay 0.
